piso_shift_ctrl: RTL and testbench
==================================

PISO_SHIFT_CTRL -- requirements
Module: piso_shift_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the word length in bits; legal range 2..32.
REQ-002 Parameter GAP, default 1, SHALL set the number of idle cycles inserted after each frame; legal range 0..15.
REQ-003 Port clk, input, 1: the single clock; all state SHALL change on its rising edge only.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port in_data, input, WIDTH: parallel word to serialize.
REQ-006 Port in_valid, input, 1: in_data is valid.
REQ-007 Port in_ready, output, 1: controller accepts a word this cycle.
REQ-008 Port abort, input, 1: synchronous request to cancel the current frame.
REQ-009 Port serial_out, output, 1: serial data, MSB first.
REQ-010 Port frame, output, 1: serial_out carries a valid bit this cycle.
REQ-011 Port done, output, 1: one-cycle pulse marking the last bit of a completed frame.
REQ-012 Port busy, output, 1: controller is not in IDLE.

Function
REQ-013 The controller SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-014 in_ready SHALL equal (state==IDLE) & ~abort; it is combinational from registered state.
REQ-015 A handshake occurs when in_valid & in_ready are high at a rising edge E0.
  - At E0, in_data SHALL be captured into the shift register and the state SHALL move to SHIFT.
REQ-016 In SHIFT, serial_out SHALL present bits WIDTH-1 down to 0, one per cycle, for exactly WIDTH cycles after E0.
  - frame SHALL be 1 in exactly those WIDTH cycles.
REQ-017 done SHALL be 1 only in the cycle carrying bit 0 of a non-aborted frame.
REQ-018 After the bit-0 cycle, the state SHALL move to GAP for GAP cycles, or directly to IDLE when GAP=0.
REQ-019 In GAP, the controller SHALL hold frame=0 and serial_out=0, and SHALL ignore in_valid.
REQ-020 The bit counter SHALL be a down-counter of width clog2(WIDTH+1).
  - It SHALL load WIDTH-1 at E0 and leave SHIFT when it reaches 0; no wrap-around SHALL occur.
REQ-021 Minimum frame period SHALL be WIDTH+GAP+1 cycles, because one IDLE cycle is required per handshake.
REQ-022 abort sampled high in SHIFT or GAP SHALL force the state to IDLE at that edge.
  - It SHALL clear the shift register, give serial_out=0 and frame=0 from the next cycle, and suppress done.
REQ-023 abort and in_valid high together in IDLE SHALL leave the state in IDLE; the word is not accepted.
REQ-024 abort on the bit-0 cycle SHALL suppress done; the frame counts as aborted.
REQ-025 Outside SHIFT, serial_out SHALL be 0.
REQ-026 busy SHALL be 1 in SHIFT and GAP, and 0 in IDLE.

Reset
REQ-027 While reset is high, the outputs SHALL be:
  - state=IDLE, shift register=0, bit counter=0 and gap counter=0;
  - serial_out=0, frame=0, done=0, busy=0 and in_ready=1.
REQ-028 reset asserted mid-frame SHALL abandon the frame immediately, without waiting for a clock, and SHALL produce no done.
REQ-029 The first handshake SHALL be possible at the first rising edge after reset deasserts.

Structure
REQ-030 The state encoding (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2) SHALL live in shared package piso_ctrl_pkg.
  - The WIDTH and GAP defaults SHALL live in the same package.
REQ-031 The loadable down-counter SHALL be a separate sub-module piso_bit_counter.
  - It SHALL be instantiated twice: once for bits and once for gap cycles.
REQ-032 The shift register and the FSM SHALL reside in piso_shift_ctrl; there SHALL be no other sub-modules.

Verification (WIDTH=8, GAP=1 unless stated)
REQ-033 Single frame: handshake in_data=8'hA5.
  - serial_out SHALL be 1,0,1,0,0,1,0,1 with frame=1 for 8 cycles.
  - done SHALL be high on the 8th cycle, followed by 1 GAP cycle; in_ready SHALL then return to 1.
REQ-034 Back-to-back frames: in_valid held high with 8'hFF then 8'h00.
  - The second handshake SHALL occur exactly 10 cycles after the first.
  - The bit streams SHALL be 8 ones then 8 zeros, with frame=0 during the gap and IDLE cycles.
REQ-035 Abort: handshake 8'hC3, then abort=1 during the 3rd bit.
  - serial_out SHALL read 1,1,0, then 0 with frame=0.
  - done SHALL never pulse, and in_ready SHALL be 1 on the next cycle.
REQ-036 Asynchronous reset: reset pulsed between clock edges during bit 5 of 8'h5A.
  - Outputs SHALL match REQ-027 before the next edge.
  - No done SHALL occur, and a new word SHALL be accepted on the first edge after release.
REQ-037 GAP=0 and WIDTH=4: continuous in_valid with 4'h9, 4'h6.
  - Frames SHALL repeat every 5 cycles with serial 1,0,0,1 then 0,1,1,0.
REQ-038 Simultaneous abort and in_valid in IDLE with 8'h81: no capture, frame stays 0, busy stays 0.

Source files
------------

// File: rtl/piso_ctrl_pkg.sv
// rtl/piso_ctrl_pkg.sv - shared state encoding and parameter defaults for the PISO controller
package piso_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_GAP   = 1;
    localparam int GAP_CW    = 4;

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - loadable saturating down-counter used for bit and gap timing
module piso_bit_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic          dec_i,
    input  logic [CW-1:0] load_val_i,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Decrement stops at zero so the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/piso_shift_ctrl.sv
// rtl/piso_shift_ctrl.sv - parallel-in serial-out shifter with abortable frames and inter-frame gap
module piso_shift_ctrl
    import piso_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             serial_out,
    output logic             frame,
    output logic             done,
    output logic             busy
);

    localparam int                CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     BIT_LOAD = CW'(WIDTH - 1);
    localparam logic [GAP_CW-1:0] GAP_LOAD = (GAP > 0) ? GAP_CW'(GAP - 1) : '0;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]      bit_cnt;
    logic [GAP_CW-1:0]  gap_cnt;
    logic               accept, bit_zero, gap_zero;
    logic               in_shift, in_gap;

    assign in_shift = (state_q == ST_SHIFT);
    assign in_gap   = (state_q == ST_GAP);
    assign accept   = in_valid & in_ready;
    assign bit_zero = (bit_cnt == '0);
    assign gap_zero = (gap_cnt == '0);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shift_d = in_data;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    shift_d = '0;
                end else begin
                    shift_d = shift_q << 1;
                    if (bit_zero)
                        state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (abort || gap_zero)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                shift_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

    piso_bit_counter #(.CW(CW)) u_bit_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (abort & busy),
        .load_i     (accept),
        .dec_i      (in_shift & ~abort),
        .load_val_i (BIT_LOAD),
        .count_o    (bit_cnt)
    );

    // Gap counter is armed on the bit-0 cycle so GAP state lasts exactly GAP cycles.
    piso_bit_counter #(.CW(GAP_CW)) u_gap_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (abort & busy),
        .load_i     (in_shift & bit_zero & ~abort),
        .dec_i      (in_gap & ~abort),
        .load_val_i (GAP_LOAD),
        .count_o    (gap_cnt)
    );

    assign in_ready   = (state_q == ST_IDLE) & ~abort;
    assign busy       = (state_q != ST_IDLE);
    assign frame      = in_shift;
    assign serial_out = in_shift & shift_q[WIDTH-1];
    assign done       = in_shift & bit_zero & ~abort;

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// tb/tb_piso_shift_ctrl.sv - randomized and directed self-checking bench for piso_shift_ctrl
module tb_piso_shift_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data0;
    logic       in_valid0, abort0;
    logic       in_ready0, serial0, frame0, done0, busy0;
    logic [3:0] in_data1;
    logic       in_valid1, abort1;
    logic       in_ready1, serial1, frame1, done1, busy1;

    always #5 clk = ~clk;

    piso_shift_ctrl #(.WIDTH(8), .GAP(1)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .abort(abort0), .serial_out(serial0),
        .frame(frame0), .done(done0), .busy(busy0)
    );

    piso_shift_ctrl #(.WIDTH(4), .GAP(0)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .abort(abort1), .serial_out(serial1),
        .frame(frame1), .done(done1), .busy(busy1)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          mw[2] = '{8, 4};
    int          mg[2] = '{1, 0};
    bit          act[2];
    int          n[2];
    logic [31:0] word[2];
    int          acc_t[2];
    int          prev_t[2];
    logic [31:0] slog[2];
    int          dcount[2];
    int          cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {in_ready, busy, frame, serial_out, done} from cycles elapsed since acceptance.
    function automatic logic [4:0] expect_outs(input int i, input bit a);
        if (!act[i])
            return {!a, 4'b0000};
        if (n[i] <= mw[i])
            return {1'b0, 1'b1, 1'b1, word[i][mw[i] - n[i]], (n[i] == mw[i]) && !a};
        return 5'b01000;
    endfunction

    task automatic model_step(input int i, input bit v, input logic [31:0] d, input bit a);
        if (!act[i]) begin
            if (v && !a) begin
                act[i]    = 1'b1;
                n[i]      = 1;
                word[i]   = d;
                prev_t[i] = acc_t[i];
                acc_t[i]  = cyc;
            end
        end else if (a) begin
            act[i] = 1'b0;
        end else begin
            n[i]++;
            if (n[i] > mw[i] + mg[i])
                act[i] = 1'b0;
        end
    endtask

    task automatic check_outs(input string tag);
        @(negedge clk);
        check({tag, "/w8"}, {27'd0, in_ready0, busy0, frame0, serial0, done0},
              {27'd0, expect_outs(0, abort0)});
        check({tag, "/w4"}, {27'd0, in_ready1, busy1, frame1, serial1, done1},
              {27'd0, expect_outs(1, abort1)});
        if (frame0) slog[0] = {slog[0][30:0], serial0};
        if (frame1) slog[1] = {slog[1][30:0], serial1};
        if (done0) dcount[0]++;
        if (done1) dcount[1]++;
    endtask

    task automatic edge_update();
        @(posedge clk);
        cyc++;
        model_step(0, in_valid0, {24'd0, in_data0}, abort0);
        model_step(1, in_valid1, {28'd0, in_data1}, abort1);
        #1;
    endtask

    task automatic tick(input string tag);
        check_outs(tag);
        edge_update();
    endtask

    initial begin
        in_data0 = '0; in_valid0 = 1'b0; abort0 = 1'b0;
        in_data1 = '0; in_valid1 = 1'b0; abort1 = 1'b0;
        #2;
        check("reset/w8", {27'd0, in_ready0, busy0, frame0, serial0, done0}, 32'h10);
        check("reset/w4", {27'd0, in_ready1, busy1, frame1, serial1, done1}, 32'h10);
        @(posedge clk);
        #1 reset = 1'b0;

        slog[0] = 0; dcount[0] = 0;
        in_valid0 = 1'b1; in_data0 = 8'hA5;
        tick("a5");
        in_valid0 = 1'b0;
        repeat (10) tick("a5");
        check("a5_bits", slog[0], 32'hA5);
        check("a5_done", dcount[0], 1);

        slog[0] = 0;
        in_valid0 = 1'b1; in_data0 = 8'hFF;
        tick("b2b");
        in_data0 = 8'h00;
        repeat (10) tick("b2b");
        in_valid0 = 1'b0;
        repeat (10) tick("b2b");
        check("b2b_period", acc_t[0] - prev_t[0], 10);
        check("b2b_bits", slog[0], 32'hFF00);

        slog[0] = 0; dcount[0] = 0;
        in_valid0 = 1'b1; in_data0 = 8'hC3;
        tick("abort");
        in_valid0 = 1'b0;
        repeat (2) tick("abort");
        abort0 = 1'b1;
        tick("abort");
        abort0 = 1'b0;
        repeat (3) tick("abort");
        check("abort_bits", slog[0], 32'h6);
        check("abort_nodone", dcount[0], 0);

        dcount[0] = 0;
        in_valid0 = 1'b1; in_data0 = 8'h5A;
        tick("areset");
        in_valid0 = 1'b0;
        repeat (4) tick("areset");
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("areset_outs", {27'd0, in_ready0, busy0, frame0, serial0, done0}, 32'h10);
        act[0] = 1'b0; act[1] = 1'b0;
        #1 reset = 1'b0;
        in_valid0 = 1'b1; in_data0 = 8'h3C;
        edge_update();
        check("areset_accept", acc_t[0], cyc);
        in_valid0 = 1'b0;
        repeat (11) tick("areset");
        check("areset_done", dcount[0], 1);

        abort0 = 1'b1; in_valid0 = 1'b1; in_data0 = 8'h81;
        repeat (2) tick("ab_idle");
        abort0 = 1'b0; in_valid0 = 1'b0;
        repeat (2) tick("ab_idle");

        slog[1] = 0;
        in_valid1 = 1'b1; in_data1 = 4'h9;
        tick("g0");
        in_data1 = 4'h6;
        repeat (5) tick("g0");
        in_valid1 = 1'b0;
        repeat (6) tick("g0");
        check("g0_period", acc_t[1] - prev_t[1], 5);
        check("g0_bits", slog[1], 32'h96);

        repeat (400) begin
            in_valid0 = 1'($urandom_range(0, 1));
            in_data0  = 8'($urandom);
            abort0    = ($urandom_range(0, 9) == 0);
            in_valid1 = 1'($urandom_range(0, 1));
            in_data1  = 4'($urandom);
            abort1    = ($urandom_range(0, 9) == 0);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
